ocp_reg_slave: RTL and testbench
================================

Name: ocp_reg_slave

Overview:
- Target (responder) end of the 8-bit MCmd/MAddr/MData/SCmdAccept/SData/SResp command bus driven by the UART transaction master.
- Decodes write/read commands onto a bank of RW control registers, read-only status bytes, an ID byte and an error counter.
- Returns read data with a configurable latency and flags bad accesses with an ERR response.
- Sits between the UART bridge and the prototype's control/status logic.

Parameters:
- NUM_REGS, 16: number of RW registers at addresses 0x00..NUM_REGS-1. Legal range 1..128.
- ACCEPT_WAIT, 0: extra cycles between first seeing a non-zero MCmd and asserting SCmdAccept. Legal range 0..15.
- RD_LATENCY, 2: cycles from the SCmdAccept cycle to the SResp cycle. Legal range 1..15.
- ID_VALUE, 8'hA5: constant returned when address 0xFF is read.

Ports:
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- MCmd  in  3  000 idle, 001 write, 010 read, others illegal; held by master until accepted
- MAddr  in  8  command address
- MData  in  8  write data
- SCmdAccept  out  1  one-cycle accept pulse
- SData  out  8  read data; 0 whenever SResp=00
- SResp  out  2  00 NULL, 01 DVA, 11 ERR; one-cycle pulse
- reg_q  out  8*NUM_REGS  register n drives bits [8n+7:8n]
- status_in  in  32  status bytes; byte k is read at 0xF0+k
- err_cnt  out  8  saturating count of bad accesses
- busy  out  1  high in any state other than IDLE

Behaviour:
- All outputs are registered. Reset values: SCmdAccept=0, SData=0, SResp=00, reg_q=0, err_cnt=0, busy=0. The FSM resets to IDLE.
- Asserting reset mid-transaction abandons the transaction immediately: no accept and no response follow.
- FSM states: IDLE, WAIT, ACCEPT, RD_DELAY, RESP.
- IDLE:
  - MCmd!=000 and ACCEPT_WAIT=0 -> ACCEPT.
  - MCmd!=000 and ACCEPT_WAIT>0 -> WAIT, with the counter loaded to ACCEPT_WAIT.
- WAIT:
  - Counter decrements each cycle; on reaching 0 -> ACCEPT.
  - If MCmd returns to 000 before then -> IDLE with no accept and no error.
- ACCEPT:
  - SCmdAccept=1 for exactly this cycle; MCmd, MAddr and MData are sampled at its closing edge.
  - Write: takes effect at that edge, then -> IDLE. Writes are posted and produce no SResp.
  - Read or illegal command: read data/response code is captured, then -> RD_DELAY, or straight to RESP when RD_LATENCY=1.
  - The master drops MCmd in the following cycle, so IDLE never re-accepts the same command.
- RD_DELAY: counts RD_LATENCY-1 cycles, then -> RESP.
- RESP: SResp/SData valid for this one cycle (cycle RD_LATENCY after accept), then -> IDLE.
- No command is accepted from ACCEPT until RESP has completed (one outstanding transaction only).
- Address decode:
  - 0x00..NUM_REGS-1: RW register.
  - 0xF0..0xF3: read-only status byte.
  - 0xFE: err_cnt; a write of any data clears it to 0.
  - 0xFF: read-only ID_VALUE.
  - All other addresses are unmapped.
- Bad accesses, each incrementing err_cnt (saturates at 0xFF, no wrap):
  - Read of an unmapped address: SResp=11, SData=0.
  - Write to an unmapped or read-only address: ignored, no response.
  - Illegal MCmd (011..111): accepted, no write, SResp=11.
- Clear versus increment: the counter increments only on accept of a bad access, and a clear is a legal write, so the two never occur in the same cycle.
- Status bytes are sampled from status_in in the ACCEPT cycle.
- busy is high in every state except IDLE.

Optional Feature:
- Macro: OCP_SLAVE_STATUS_RDCLR_EN.
- Defined: each status bit is a sticky latch, set on any cycle its status_in bit is 1.
  - Reading 0xF0+k returns the latched byte and clears that byte at the ACCEPT edge.
  - If a set and the read-clear land on the same cycle, the set wins and the bit stays 1.
  - Latches reset to 0.
- Not defined: status reads return status_in sampled in the ACCEPT cycle; no status state exists.

Test Plan:
- Reset, then MCmd=001, MAddr=0x03, MData=0x5A held until accept, with ACCEPT_WAIT=0 -> SCmdAccept high 1 cycle after MCmd asserts; reg_q[31:24]=0x5A on the following cycle; SResp stays 00.
- Read 0x03 with RD_LATENCY=2 -> SCmdAccept pulse; SResp=01, SData=0x5A exactly 2 cycles after the accept cycle, for 1 cycle.
- Read 0xFF -> SData=0xA5, SResp=01. Read 0x80 -> SResp=11, SData=0x00, err_cnt=1. Write 0xF1 -> no response, err_cnt=2. Write 0xFE -> err_cnt=0.
- ACCEPT_WAIT=3: MCmd=010 asserted for 2 cycles then dropped -> no accept, no response, busy returns to 0. Re-issue and hold -> accept 4 cycles after MCmd asserts.
- 256 reads of address 0x90 -> err_cnt saturates at 0xFF. Assert reset during RD_DELAY -> SResp stays 00, all outputs return to reset values.
- With OCP_SLAVE_STATUS_RDCLR_EN: pulse status_in[9] for 1 cycle, read 0xF1 -> 0x02, re-read -> 0x00. Hold status_in[9]=1 during the read -> both reads return 0x02.

Source files
------------

// File: rtl/ocp_reg_slave.sv
// OCP-style register target: RW regs, status/ID/err-count bytes; OCP_SLAVE_STATUS_RDCLR_EN makes status sticky read-clear.
// Latency: accept ACCEPT_WAIT+1 cycles after MCmd, read response RD_LATENCY cycles after accept; writes posted.
// Backpressure: MCmd held until SCmdAccept; no new command accepted until the outstanding read/error response has gone out.
module ocp_reg_slave #(
    parameter int         NUM_REGS    = 16,
    parameter int         ACCEPT_WAIT = 0,
    parameter int         RD_LATENCY  = 2,
    parameter logic [7:0] ID_VALUE    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            MCmd,
    input  logic [7:0]            MAddr,
    input  logic [7:0]            MData,
    output logic                  SCmdAccept,
    output logic [7:0]            SData,
    output logic [1:0]            SResp,
    output logic [8*NUM_REGS-1:0] reg_q,
    input  logic [31:0]           status_in,
    output logic [7:0]            err_cnt,
    output logic                  busy
);

    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;
    localparam logic [8:0] NREGS9    = 9'(NUM_REGS);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_ACCEPT, S_RD_DELAY, S_RESP} state_t;

    state_t                       state_q, state_d;
    logic [3:0]                   cnt_q, cnt_d;
    logic [NUM_REGS-1:0][7:0]     regs_q, regs_d;
    logic [7:0]                   err_q, err_d;
    logic [7:0]                   rdata_q, rdata_d;
    logic [1:0]                   rresp_q, rresp_d;
    logic                         acc_q, acc_d;
    logic [7:0]                   sdata_q, sdata_d;
    logic [1:0]                   sresp_q, sresp_d;
    logic                         busy_q, busy_d;

    logic                         is_wr, is_rd, in_accept;
    logic                         addr_reg, addr_st, addr_ec, addr_id;
    logic [7:0]                   reg_rd, stat_byte, rd_data_c;
    logic [1:0]                   rd_resp_c;
    logic                         bad_c;
    logic [31:0]                  stat_view;

    assign is_wr     = (MCmd == 3'b001);
    assign is_rd     = (MCmd == 3'b010);
    assign in_accept = (state_q == S_ACCEPT);
    assign addr_reg  = ({1'b0, MAddr} < NREGS9);
    assign addr_st   = (MAddr[7:2] == 6'b111100);
    assign addr_ec   = (MAddr == 8'hFE);
    assign addr_id   = (MAddr == 8'hFF);

`ifdef OCP_SLAVE_STATUS_RDCLR_EN
    logic [31:0] stk_q, stk_d, clr_mask;

    // A set arriving in the read-clear cycle survives because status_in is OR-ed after the clear.
    always_comb begin
        clr_mask = '0;
        if (in_accept && is_rd && addr_st)
            clr_mask = 32'hFF << {MAddr[1:0], 3'b000};
        stk_d = (stk_q & ~clr_mask) | status_in;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) stk_q <= '0;
        else          stk_q <= stk_d;
    end

    assign stat_view = stk_q;
`else
    assign stat_view = status_in;
`endif

    always_comb begin
        case (MAddr[1:0])
            2'd0:    stat_byte = stat_view[7:0];
            2'd1:    stat_byte = stat_view[15:8];
            2'd2:    stat_byte = stat_view[23:16];
            default: stat_byte = stat_view[31:24];
        endcase
    end

    always_comb begin
        reg_rd = '0;
        for (int n = 0; n < NUM_REGS; n++)
            if (MAddr == 8'(n)) reg_rd = regs_q[n];
    end

    // Decode of the command currently presented; only acted on in ACCEPT.
    always_comb begin
        rd_data_c = '0;
        rd_resp_c = RESP_ERR;
        bad_c     = 1'b0;
        if (is_rd) begin
            rd_resp_c = RESP_DVA;
            if (addr_reg)     rd_data_c = reg_rd;
            else if (addr_st) rd_data_c = stat_byte;
            else if (addr_ec) rd_data_c = err_q;
            else if (addr_id) rd_data_c = ID_VALUE;
            else begin
                rd_resp_c = RESP_ERR;
                bad_c     = 1'b1;
            end
        end else if (is_wr) begin
            bad_c = !(addr_reg || addr_ec);
        end else if (MCmd != 3'b000) begin
            bad_c = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (MCmd != 3'b000) begin
                    if (ACCEPT_WAIT == 0) begin
                        state_d = S_ACCEPT;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(ACCEPT_WAIT);
                    end
                end
            end
            S_WAIT: begin
                if (MCmd == 3'b000)  state_d = S_IDLE;
                else if (cnt_q <= 4'd1) state_d = S_ACCEPT;
                else                 cnt_d   = cnt_q - 4'd1;
            end
            S_ACCEPT: begin
                if (is_wr || MCmd == 3'b000) begin
                    state_d = S_IDLE;
                end else if (RD_LATENCY == 1) begin
                    state_d = S_RESP;
                end else begin
                    state_d = S_RD_DELAY;
                    cnt_d   = 4'(RD_LATENCY - 1);
                end
            end
            S_RD_DELAY: begin
                if (cnt_q <= 4'd1) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        acc_d   = (state_d == S_ACCEPT);
        busy_d  = (state_d != S_IDLE);
        regs_d  = regs_q;
        err_d   = err_q;
        rdata_d = rdata_q;
        rresp_d = rresp_q;
        if (in_accept) begin
            rdata_d = rd_data_c;
            rresp_d = rd_resp_c;
            if (is_wr && addr_reg) begin
                for (int n = 0; n < NUM_REGS; n++)
                    if (MAddr == 8'(n)) regs_d[n] = MData;
            end
            if (is_wr && addr_ec)             err_d = '0;
            else if (bad_c && err_q != 8'hFF) err_d = err_q + 8'd1;
        end
        sresp_d = RESP_NULL;
        sdata_d = '0;
        if (state_d == S_RESP) begin
            sresp_d = in_accept ? rd_resp_c : rresp_q;
            sdata_d = in_accept ? rd_data_c : rdata_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            regs_q  <= '0;
            err_q   <= '0;
            rdata_q <= '0;
            rresp_q <= RESP_NULL;
            acc_q   <= 1'b0;
            sdata_q <= '0;
            sresp_q <= RESP_NULL;
            busy_q  <= 1'b0;
        end else begin
            regs_q  <= regs_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            rresp_q <= rresp_d;
            acc_q   <= acc_d;
            sdata_q <= sdata_d;
            sresp_q <= sresp_d;
            busy_q  <= busy_d;
        end
    end

    assign SCmdAccept = acc_q;
    assign SData      = sdata_q;
    assign SResp      = sresp_q;
    assign reg_q      = regs_q;
    assign err_cnt    = err_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_ocp_reg_slave.sv
// Bench for ocp_reg_slave: two instances (no wait / RD_LATENCY 2, and ACCEPT_WAIT 3 / RD_LATENCY 1)
// driven by directed and random transactions against a transaction-level register model.
module tb_ocp_reg_slave;

    localparam int NR = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset_n;
    logic [2:0]       mcmd  [2];
    logic [7:0]       maddr [2];
    logic [7:0]       mdata [2];
    logic [31:0]      stat  [2];
    logic             acc   [2];
    logic [7:0]       sdata [2];
    logic [1:0]       sresp [2];
    logic [8*NR-1:0]  regq  [2];
    logic [7:0]       errc  [2];
    logic             busy  [2];

    ocp_reg_slave #(.NUM_REGS(NR), .ACCEPT_WAIT(0), .RD_LATENCY(2), .ID_VALUE(8'hA5)) u_dut0 (
        .clk(clk), .reset_n(reset_n), .MCmd(mcmd[0]), .MAddr(maddr[0]), .MData(mdata[0]),
        .SCmdAccept(acc[0]), .SData(sdata[0]), .SResp(sresp[0]), .reg_q(regq[0]),
        .status_in(stat[0]), .err_cnt(errc[0]), .busy(busy[0]));

    ocp_reg_slave #(.NUM_REGS(NR), .ACCEPT_WAIT(3), .RD_LATENCY(1), .ID_VALUE(8'h3C)) u_dut1 (
        .clk(clk), .reset_n(reset_n), .MCmd(mcmd[1]), .MAddr(maddr[1]), .MData(mdata[1]),
        .SCmdAccept(acc[1]), .SData(sdata[1]), .SResp(sresp[1]), .reg_q(regq[1]),
        .status_in(stat[1]), .err_cnt(errc[1]), .busy(busy[1]));

    // Reference model: register contents, error count and sticky status per instance.
    logic [7:0]  m_regs [2][NR];
    int          m_err  [2];
    logic [31:0] m_stk  [2];

    int n_chk  = 0;
    int n_pass = 0;

    function automatic int aw_of(int i); return (i == 0) ? 0 : 3; endfunction
    function automatic int rl_of(int i); return (i == 0) ? 2 : 1; endfunction
    function automatic logic [7:0] id_of(int i); return (i == 0) ? 8'hA5 : 8'h3C; endfunction

    function automatic logic [127:0] m_regvec(int i);
        logic [127:0] v;
        v = '0;
        for (int n = 0; n < NR; n++) v[8*n +: 8] = m_regs[i][n];
        return v;
    endfunction

    task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic bump(int i);
        if (m_err[i] < 255) m_err[i]++;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            for (int n = 0; n < NR; n++) m_regs[i][n] = '0;
            m_err[i] = 0;
            m_stk[i] = '0;
        end
    endtask

    // One full master transaction with timing and result checks.
    task automatic do_txn(int i, logic [2:0] cmd, logic [7:0] addr, logic [7:0] data);
        bit         hasr, seen, dirty;
        logic [1:0] eresp;
        logic [7:0] edata;
        int         n, a, k;
        hasr = 0; eresp = 2'b00; edata = 8'h00; a = int'(addr);
        @(negedge clk);
        mcmd[i] = cmd; maddr[i] = addr; mdata[i] = data;
        m_stk[i] |= stat[i];
        if (cmd == 3'b001) begin
            if (a < NR)            m_regs[i][a] = data;
            else if (a == 'hFE)    m_err[i] = 0;
            else                   bump(i);
        end else if (cmd == 3'b010) begin
            hasr = 1; eresp = 2'b01;
            if (a < NR) edata = m_regs[i][a];
            else if (a >= 'hF0 && a <= 'hF3) begin
                k = a - 'hF0;
`ifdef OCP_SLAVE_STATUS_RDCLR_EN
                edata = m_stk[i][8*k +: 8];
                m_stk[i][8*k +: 8] = stat[i][8*k +: 8];
`else
                edata = stat[i][8*k +: 8];
`endif
            end
            else if (a == 'hFE) edata = 8'(m_err[i]);
            else if (a == 'hFF) edata = id_of(i);
            else begin eresp = 2'b11; bump(i); end
        end else begin
            hasr = 1; eresp = 2'b11; bump(i);
        end

        n = 0;
        do begin @(negedge clk); n++; end while (acc[i] !== 1'b1 && n < 40);
        chk("accept_latency", n, aw_of(i) + 1);
        chk("busy_at_accept", busy[i], 1'b1);
        chk("null_at_accept", sresp[i], 2'b00);

        n = 0; seen = 0; dirty = 0;
        do begin
            @(negedge clk); n++;
            if (n == 1) begin
                mcmd[i] = 3'b000; maddr[i] = 8'($urandom); mdata[i] = 8'($urandom);
            end
            if (acc[i] !== 1'b0) seen = 1;
            if (sresp[i] == 2'b00 && sdata[i] != 8'h00) dirty = 1;
        end while (sresp[i] == 2'b00 && n < (hasr ? 20 : rl_of(i) + 3));
        if (hasr) begin
            chk("resp_latency", n, rl_of(i));
            chk("sresp", sresp[i], eresp);
            chk("sdata", sdata[i], edata);
        end else begin
            chk("write_no_resp", sresp[i], 2'b00);
        end
        chk("no_reaccept", seen, 1'b0);
        chk("sdata_zero_when_null", dirty, 1'b0);
        @(negedge clk);
        chk("resp_one_cycle", sresp[i], 2'b00);
        chk("busy_idle", busy[i], 1'b0);
        chk("reg_q", regq[i], m_regvec(i));
        chk("err_cnt", errc[i], m_err[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  i, r, n;
        bit  seen;
        logic [2:0] cmd;
        logic [7:0] addr;

        reset_n = 1'b0;
        for (int j = 0; j < 2; j++) begin
            mcmd[j] = '0; maddr[j] = '0; mdata[j] = '0; stat[j] = '0;
        end
        model_reset();
        repeat (2) @(negedge clk);
        for (int j = 0; j < 2; j++) begin
            chk("rst_accept", acc[j], 1'b0);
            chk("rst_sresp", sresp[j], 2'b00);
            chk("rst_sdata", sdata[j], 8'h00);
            chk("rst_reg_q", regq[j], 128'h0);
            chk("rst_err_cnt", errc[j], 8'h00);
            chk("rst_busy", busy[j], 1'b0);
        end
        @(negedge clk);
        reset_n = 1'b1;

        // Directed sequence from the basic-access scenarios.
        do_txn(0, 3'b001, 8'h03, 8'h5A);
        chk("reg3_written", regq[0][31:24], 8'h5A);
        do_txn(0, 3'b010, 8'h03, 8'h00);
        do_txn(0, 3'b010, 8'hFF, 8'h00);
        do_txn(0, 3'b010, 8'h80, 8'h00);
        chk("err_after_unmapped_read", errc[0], 8'h01);
        do_txn(0, 3'b001, 8'hF1, 8'h77);
        chk("err_after_ro_write", errc[0], 8'h02);
        do_txn(0, 3'b001, 8'hFE, 8'h00);
        chk("err_after_clear", errc[0], 8'h00);
        do_txn(0, 3'b101, 8'h02, 8'h00);
        do_txn(1, 3'b010, 8'hFF, 8'h00);

        // Command withdrawn while waiting: no accept, no response, no error.
        @(negedge clk);
        mcmd[1] = 3'b010; maddr[1] = 8'h90;
        @(negedge clk);
        chk("busy_in_wait", busy[1], 1'b1);
        @(negedge clk);
        mcmd[1] = 3'b000;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (acc[1] !== 1'b0 || sresp[1] !== 2'b00) seen = 1;
        end
        chk("withdrawn_no_activity", seen, 1'b0);
        chk("withdrawn_busy", busy[1], 1'b0);
        chk("withdrawn_err", errc[1], m_err[1]);
        do_txn(1, 3'b010, 8'h90, 8'h00);

        // Random mix of reads, writes and illegal commands on both instances.
        repeat (200) begin
            i = $urandom_range(0, 1);
            r = $urandom_range(0, 9);
            if (r < 4)      cmd = 3'b001;
            else if (r < 8) cmd = 3'b010;
            else            cmd = 3'($urandom_range(3, 7));
            r = $urandom_range(0, 11);
            if (r < 5)       addr = 8'($urandom_range(0, NR - 1));
            else if (r < 7)  addr = 8'($urandom_range(240, 243));
            else if (r == 7) addr = 8'hFE;
            else if (r == 8) addr = 8'hFF;
            else             addr = 8'($urandom_range(0, 255));
            @(negedge clk);
            stat[i] = $urandom;
            do_txn(i, cmd, addr, 8'($urandom));
        end

`ifdef OCP_SLAVE_STATUS_RDCLR_EN
        // Sticky status: drain, then single-cycle pulse and held-bit cases.
        @(negedge clk);
        stat[0] = '0;
        for (int b = 0; b < 4; b++) do_txn(0, 3'b010, 8'(8'hF0 + b), 8'h00);
        @(negedge clk);
        stat[0] = 32'h0000_0200;
        @(negedge clk);
        m_stk[0] |= stat[0];
        stat[0] = '0;
        do_txn(0, 3'b010, 8'hF1, 8'h00);
        chk("sticky_first_read", sdata[0] == 8'h00, 1'b1);
        do_txn(0, 3'b010, 8'hF1, 8'h00);
        @(negedge clk);
        stat[0] = 32'h0000_0200;
        do_txn(0, 3'b010, 8'hF1, 8'h00);
        do_txn(0, 3'b010, 8'hF1, 8'h00);
        @(negedge clk);
        stat[0] = '0;
`endif

        // Error counter saturation.
        do_txn(0, 3'b001, 8'hFE, 8'h00);
        repeat (260) do_txn(0, 3'b010, 8'h90, 8'h00);
        chk("err_saturated", errc[0], 8'hFF);

        // Reset while a read is in its delay cycle.
        @(negedge clk);
        mcmd[0] = 3'b010; maddr[0] = 8'h03;
        n = 0;
        do begin @(negedge clk); n++; end while (acc[0] !== 1'b1 && n < 40);
        chk("rst_mid_accept_latency", n, 1);
        @(negedge clk);
        mcmd[0] = 3'b000;
        reset_n = 1'b0;
        #1;
        chk("midrst_accept", acc[0], 1'b0);
        chk("midrst_sresp", sresp[0], 2'b00);
        chk("midrst_sdata", sdata[0], 8'h00);
        chk("midrst_reg_q", regq[0], 128'h0);
        chk("midrst_err_cnt", errc[0], 8'h00);
        chk("midrst_busy", busy[0], 1'b0);
        seen = 0;
        repeat (3) begin
            @(negedge clk);
            if (sresp[0] !== 2'b00 || acc[0] !== 1'b0) seen = 1;
        end
        reset_n = 1'b1;
        model_reset();
        repeat (2) begin
            @(negedge clk);
            if (sresp[0] !== 2'b00 || acc[0] !== 1'b0) seen = 1;
        end
        chk("midrst_no_response", seen, 1'b0);
        do_txn(0, 3'b010, 8'h03, 8'h00);
        do_txn(1, 3'b010, 8'h05, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
